operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 148 ++++++++++++++
 tb/tb_operand_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - debounced pushbutton loader latching switch operands for the ALU core
// All raw inputs are double-synchronized; a four-state debounce FSM gates the operand latch.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic [3:0] sw_sel,
  input  logic       btn_load,
  output logic [3:0] data_a,
  output logic [3:0] data_b,
  output logic [3:0] alu_sel,
  output logic       load_valid,
  output logic [7:0] load_count,
  output logic [1:0] btn_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [12:0] sync1_q;
  logic [12:0] sync2_q;
  logic [3:0]  sw_a_s;
  logic [3:0]  sw_b_s;
  logic [3:0]  sw_sel_s;
  logic        btn_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch;

  logic [3:0] data_a_q, data_b_q, alu_sel_q;
  logic       load_valid_q;
  logic [7:0] load_count_q;

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_load, sw_sel, sw_b, sw_a};
      sync2_q <= sync1_q;
    end
  end

  assign sw_a_s   = sync2_q[3:0];
  assign sw_b_s   = sync2_q[7:4];
  assign sw_sel_s = sync2_q[11:8];
  assign btn_s    = sync2_q[12];

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter holds the number of consecutive samples at the level that would change state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          latch   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      data_a_q     <= '0;
      data_b_q     <= '0;
      alu_sel_q    <= '0;
      load_valid_q <= 1'b0;
      load_count_q <= '0;
    end else begin
      load_valid_q <= latch;
      if (latch) begin
        data_a_q     <= sw_a_s;
        data_b_q     <= sw_b_s;
        alu_sel_q    <= sw_sel_s;
        load_count_q <= load_count_q + 8'd1;
      end
    end
  end

  assign data_a     = data_a_q;
  assign data_b     = data_b_q;
  assign alu_sel    = alu_sel_q;
  assign load_valid = load_valid_q;
  assign load_count = load_count_q;
  assign btn_state  = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - scoreboard bench for operand_loader with a run-length debounce model
module tb_operand_loader;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_a = '0, sw_b = '0, sw_sel = '0;
  logic       btn_load = 1'b0;
  logic [3:0] data_a, data_b, alu_sel;
  logic       load_valid;
  logic [7:0] load_count;
  logic [1:0] btn_state;

  operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_100Mhz(clk), .reset(reset), .sw_a(sw_a), .sw_b(sw_b), .sw_sel(sw_sel),
    .btn_load(btn_load), .data_a(data_a), .data_b(data_b), .alu_sel(alu_sel),
    .load_valid(load_valid), .load_count(load_count), .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_loads = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the button is debounced when the last D synchronized samples
  // (raw samples two clocks old) all disagree with the current debounced level.
  logic [19:0] sbq[$];
  logic [12:0] h1 = '0, h2 = '0, cur;
  bit          deb = 1'b0;
  int          run = 0;
  logic [3:0]  m_a = '0, m_b = '0, m_sel = '0;
  logic [7:0]  m_cnt = '0;
  logic        m_lv = 1'b0;
  logic [1:0]  m_st = '0;

  always @(posedge clk) begin
    if (reset) begin
      h1 = '0; h2 = '0; deb = 1'b0; run = 0;
      m_a = '0; m_b = '0; m_sel = '0; m_cnt = '0; m_lv = 1'b0; m_st = '0;
    end else begin
      cur = h2;
      h2 = h1;
      h1 = {btn_load, sw_sel, sw_b, sw_a};
      m_lv = 1'b0;
      if (cur[12] != deb) begin
        run++;
        if (run == D) begin
          deb = cur[12];
          run = 0;
          if (deb) begin
            m_a = cur[3:0]; m_b = cur[7:4]; m_sel = cur[11:8];
            m_cnt = m_cnt + 8'd1;
            m_lv = 1'b1;
            sbq.push_back({m_a, m_b, m_sel, m_cnt});
            exp_loads++;
          end
        end
      end else begin
        run = 0;
      end
      m_st = deb ? ((run > 0) ? 2'd3 : 2'd2) : ((run > 0) ? 2'd1 : 2'd0);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (load_valid) begin
        pulses++;
        if (sbq.size() == 0) begin
          chk("unexpected_load_valid", 1, 0);
        end else begin
          chk("load_operands", int'({data_a, data_b, alu_sel, load_count}), int'(sbq.pop_front()));
        end
      end
      chk("steady_outputs", int'({data_a, data_b, alu_sel, load_count, btn_state}),
          int'({m_a, m_b, m_sel, m_cnt, m_st}));
      chk("load_valid_level", int'(load_valid), int'(m_lv));
    end
  end

  task automatic press(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                       input int hold, input int low, input bit chk_lat);
    int lat;
    lat = -1;
    sw_a = a; sw_b = b; sw_sel = sel; btn_load = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (load_valid && lat < 0) lat = k;
    end
    if (chk_lat) chk("press_latency", lat, 2 + D);
    btn_load = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, lat;
    int trace[$];
    int exp_tr[5];
    logic [1:0] last;
    bit pat[13];
    exp_tr = '{2, 3, 2, 3, 0};
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with button and switches active, then a full qualification after release
    reset = 1'b1; btn_load = 1'b1; sw_a = 4'hA; sw_b = 4'h6; sw_sel = 4'hC;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("reset_outputs", int'({data_a, data_b, alu_sel, load_valid, load_count, btn_state}), 0);
    reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (load_valid && lat < 0) lat = k;
    end
    chk("load_after_reset_latency", lat, 2 + D);
    btn_load = 1'b0;
    repeat (8) @(negedge clk);

    // Clean press
    pulse_reset();
    repeat (2) @(negedge clk);
    p0 = pulses;
    press(4'd3, 4'd5, 4'd2, 20, 8, 1'b1);
    chk("clean_outputs", int'({data_a, data_b, alu_sel}), int'({4'd3, 4'd5, 4'd2}));
    chk("clean_count", int'(load_count), 1);
    chk("clean_pulses", pulses - p0, 1);

    // Bounce never qualifies
    p0 = pulses;
    sw_a = 4'hF; sw_b = 4'hE; sw_sel = 4'hD;
    repeat (5) begin
      btn_load = 1'b1; repeat (2) @(negedge clk);
      btn_load = 1'b0; @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_state", int'(btn_state), 0);
    chk("bounce_outputs", int'({data_a, data_b, alu_sel, load_count}), int'({4'd3, 4'd5, 4'd2, 8'd1}));

    // Release bounce
    p0 = pulses;
    press(4'd1, 4'd2, 4'd3, 10, 0, 1'b0);
    last = btn_state;
    trace.push_back(int'(last));
    for (int i = 0; i < 13; i++) begin
      btn_load = pat[i];
      @(negedge clk);
      if (btn_state != last) begin
        last = btn_state;
        trace.push_back(int'(last));
      end
    end
    chk("release_trace_len", trace.size(), 5);
    for (int i = 0; i < 5; i++) if (i < trace.size()) chk("release_trace", trace[i], exp_tr[i]);
    chk("release_pulses", pulses - p0, 1);

    // Switch isolation while held
    sw_a = 4'd3; sw_b = 4'd7; sw_sel = 4'd1; btn_load = 1'b1;
    repeat (8) @(negedge clk);
    sw_a = 4'd9;
    repeat (6) @(negedge clk);
    chk("isolation_held", int'(data_a), 3);
    btn_load = 1'b0;
    repeat (8) @(negedge clk);
    chk("isolation_released", int'(data_a), 3);
    press(4'd9, 4'd7, 4'd1, 8, 8, 1'b1);
    chk("isolation_next_load", int'(data_a), 9);

    // Reset in the third PRESS_WAIT cycle
    p0 = pulses;
    sw_a = 4'd6; sw_b = 4'd6; sw_sel = 4'd6; btn_load = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midpress_reset_outputs", int'({data_a, data_b, alu_sel, load_valid, load_count, btn_state}), 0);
    reset = 1'b0; btn_load = 1'b0;
    repeat (8) @(negedge clk);
    chk("midpress_no_pulse", pulses - p0, 0);
    press(4'd4, 4'd8, 4'd12, 8, 8, 1'b1);
    chk("midpress_next_count", int'(load_count), 1);

    // Counter wrap
    pulse_reset();
    repeat (2) @(negedge clk);
    p0 = pulses;
    repeat (256) press(4'($urandom), 4'($urandom), 4'($urandom), 7, 7, 1'b0);
    chk("wrap_count", int'(load_count), 0);
    chk("wrap_pulses", pulses - p0, 256);

    // Random levels, switch churn and occasional resets
    repeat (300) begin
      int len;
      btn_load = ~btn_load;
      len = int'($urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) reset = 1'b1;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 2) == 0) sw_a = 4'($urandom);
        if ($urandom_range(0, 2) == 0) sw_b = 4'($urandom);
        if ($urandom_range(0, 2) == 0) sw_sel = 4'($urandom);
        @(negedge clk);
        reset = 1'b0;
      end
    end
    btn_load = 1'b0;
    repeat (12) @(negedge clk);

    chk("scoreboard_empty", sbq.size(), 0);
    chk("total_pulses", pulses, exp_loads);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
